// File: rtl/sync_width_conv_fifo.sv
// Single-clock width-converting FIFO with unit-granular occupancy,
// runtime almost thresholds, optional first-word-fall-through and sticky errors.
module sync_width_conv_fifo #(
    parameter int WR_DATA_WIDTH    = 128,
    parameter int RD_DATA_WIDTH    = 16,
    parameter int UNIT_DEPTH_WIDTH = 12,
    parameter int FWFT             = 0,
    localparam int U = (WR_DATA_WIDTH < RD_DATA_WIDTH) ? WR_DATA_WIDTH : RD_DATA_WIDTH,
    localparam int WR_R = WR_DATA_WIDTH / U,
    localparam int RD_R = RD_DATA_WIDTH / U,
    localparam int WR_DEPTH_WIDTH = UNIT_DEPTH_WIDTH - $clog2(WR_R),
    localparam int RD_DEPTH_WIDTH = UNIT_DEPTH_WIDTH - $clog2(RD_R)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [WR_DATA_WIDTH-1:0]  wr_data,
    output logic                      wr_full,
    output logic                      almost_full,
    output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
    input  logic [WR_DEPTH_WIDTH:0]   almost_full_num,
    input  logic                      rd_en,
    output logic [RD_DATA_WIDTH-1:0]  rd_data,
    output logic                      rd_valid,
    output logic                      rd_empty,
    output logic                      almost_empty,
    output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
    input  logic [RD_DEPTH_WIDTH:0]   almost_empty_num,
    output logic                      overflow,
    output logic                      underflow,
    input  logic                      clr_err
);

    localparam int UW   = UNIT_DEPTH_WIDTH;
    localparam int MAXR = (WR_R > RD_R) ? WR_R : RD_R;
    localparam int MW   = MAXR * U;
    localparam int AW   = UW - $clog2(MAXR);
    localparam int WLG  = $clog2(WR_R);
    localparam int RLG  = $clog2(RD_R);
    localparam logic [UW:0] CAP  = {1'b1, {UW{1'b0}}};
    localparam logic [UW:0] WR_U = (UW+1)'(WR_R);
    localparam logic [UW:0] RD_U = (UW+1)'(RD_R);

    // Each RAM row holds one wide word; the narrow side selects a lane.
    logic [MW-1:0]            mem [2**AW];
    logic [UW-1:0]            wr_ptr, rd_ptr;
    logic [UW:0]              count, count_nx;
    logic [AW-1:0]            waddr, raddr;
    int                       wr_off, rd_off;
    logic [RD_DATA_WIDTH-1:0] head, rd_data_q;
    logic                     wr_acc, rd_acc, rd_valid_q;

    function automatic logic [WR_DEPTH_WIDTH:0] wr_lvl(input logic [UW:0] c);
        logic [UW+1:0] t;
        t = {1'b0, c} + (UW+2)'(WR_R - 1);
        return (WR_DEPTH_WIDTH+1)'(t >> WLG);
    endfunction

    function automatic logic [RD_DEPTH_WIDTH:0] rd_lvl(input logic [UW:0] c);
        return (RD_DEPTH_WIDTH+1)'(c >> RLG);
    endfunction

    assign wr_full        = count > (CAP - WR_U);
    assign rd_empty       = count < RD_U;
    assign wr_acc         = wr_en & ~wr_full;
    assign rd_acc         = rd_en & ~rd_empty;
    assign wr_water_level = wr_lvl(count);
    assign rd_water_level = rd_lvl(count);

    assign waddr  = wr_ptr[UW-1 -: AW];
    assign raddr  = rd_ptr[UW-1 -: AW];
    assign wr_off = U * int'(wr_ptr & UW'(MAXR - 1));
    assign rd_off = U * int'(rd_ptr & UW'(MAXR - 1));
    assign head   = mem[raddr][rd_off +: RD_DATA_WIDTH];

    always_comb begin
        count_nx = count;
        if (wr_acc) count_nx = count_nx + WR_U;
        if (rd_acc) count_nx = count_nx - RD_U;
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) mem[waddr][wr_off +: WR_DATA_WIDTH] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            almost_full  <= (almost_full_num == '0);
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + UW'(WR_R);
            if (rd_acc) begin
                rd_ptr    <= rd_ptr + UW'(RD_R);
                rd_data_q <= head;
            end
            rd_valid_q   <= rd_acc;
            count        <= count_nx;
            almost_full  <= wr_lvl(count_nx) >= almost_full_num;
            almost_empty <= rd_lvl(count_nx) <= almost_empty_num;
            overflow     <= (overflow & ~clr_err) | (wr_en & wr_full);
            underflow    <= (underflow & ~clr_err) | (rd_en & rd_empty);
        end
    end

    assign rd_data  = (FWFT != 0) ? (rd_empty ? '0 : head) : rd_data_q;
    assign rd_valid = (FWFT != 0) ? ~rd_empty : rd_valid_q;

endmodule
